// File: rtl/idex_hazard_resp_v.sv
// ID/EX pipeline register with stall/flush handling, EX operand forwarding, hazard counters and stall watchdog.
// Latency: ID fields appear at the ID/EX outputs one edge after capture; pc_en, ifid_en and ex_op* are combinational.
module idex_hazard_resp_v #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_memRead,
    input  logic              id_memWrite,
    input  logic              id_regWrite,
    input  logic [DATA_W-1:0] id_op1,
    input  logic [DATA_W-1:0] id_op2,
    input  logic [1:0]        forwA,
    input  logic [1:0]        forwB,
    input  logic [DATA_W-1:0] exmem_alu,
    input  logic [DATA_W-1:0] memwb_wdata,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_valid,
    output logic [4:0]        idex_rs1,
    output logic [4:0]        idex_rs2,
    output logic [4:0]        idex_rd,
    output logic              idex_memRead,
    output logic              idex_memWrite,
    output logic              idex_regWrite,
    output logic [DATA_W-1:0] ex_opA,
    output logic [DATA_W-1:0] ex_opB,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic              stall_err
);

    localparam int RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(MAX_STALL);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {RUN, STALLED} state_t;

    state_t            state;
    logic [RUN_W-1:0]  run_cnt;
    logic [DATA_W-1:0] idex_op1;
    logic [DATA_W-1:0] idex_op2;
    logic              stall_eff;
    logic              bubble;

    // A flush wins over a stall so a mispredicted path never freezes the front end.
    assign stall_eff = stall & ~flush;
    assign bubble    = stall | flush;
    assign pc_en     = ~stall_eff;
    assign ifid_en   = ~stall_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid    <= 1'b0;
            idex_rs1      <= '0;
            idex_rs2      <= '0;
            idex_rd       <= '0;
            idex_memRead  <= 1'b0;
            idex_memWrite <= 1'b0;
            idex_regWrite <= 1'b0;
            idex_op1      <= '0;
            idex_op2      <= '0;
        end else if (bubble) begin
            idex_valid    <= 1'b0;
            idex_rs1      <= '0;
            idex_rs2      <= '0;
            idex_rd       <= '0;
            idex_memRead  <= 1'b0;
            idex_memWrite <= 1'b0;
            idex_regWrite <= 1'b0;
            idex_op1      <= '0;
            idex_op2      <= '0;
        end else begin
            idex_valid    <= id_valid;
            idex_rs1      <= id_rs1;
            idex_rs2      <= id_rs2;
            idex_rd       <= id_rd;
            idex_memRead  <= id_memRead;
            idex_memWrite <= id_memWrite;
            idex_regWrite <= id_regWrite;
            idex_op1      <= id_op1;
            idex_op2      <= id_op2;
        end
    end

    // Code 2'b11 is reserved and behaves like "no forwarding".
    always_comb begin
        ex_opA = idex_op1;
        case (forwA)
            2'b01:   ex_opA = exmem_alu;
            2'b10:   ex_opA = memwb_wdata;
            default: ex_opA = idex_op1;
        endcase
    end

    always_comb begin
        ex_opB = idex_op2;
        case (forwB)
            2'b01:   ex_opB = exmem_alu;
            2'b10:   ex_opB = memwb_wdata;
            default: ex_opB = idex_op2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_W'(1);
            if (stall_eff && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Watchdog: run_cnt tracks consecutive stall cycles; stall_err is sticky once the run exceeds MAX_STALL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            run_cnt   <= '0;
            stall_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (stall_eff) begin
                        state   <= STALLED;
                        run_cnt <= RUN_W'(1);
                        if (MAX_STALL == 0)
                            stall_err <= 1'b1;
                    end
                end
                STALLED: begin
                    if (stall_eff) begin
                        if (run_cnt != RUN_SAT)
                            run_cnt <= run_cnt + RUN_W'(1);
                        if (run_cnt >= RUN_LIM)
                            stall_err <= 1'b1;
                    end else begin
                        state   <= RUN;
                        run_cnt <= '0;
                    end
                end
                default: begin
                    state   <= RUN;
                    run_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idex_hazard_resp_v.sv
// Self-checking bench for idex_hazard_resp_v against a behavioural pipeline model.
module tb_idex_hazard_resp_v;

    localparam int DATA_W    = 32;
    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 3;
    localparam int CNT_TOP   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall, flush, id_valid;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic              id_memRead, id_memWrite, id_regWrite;
    logic [DATA_W-1:0] id_op1, id_op2, exmem_alu, memwb_wdata;
    logic [1:0]        forwA, forwB;
    logic              pc_en, ifid_en, idex_valid;
    logic [4:0]        idex_rs1, idex_rs2, idex_rd;
    logic              idex_memRead, idex_memWrite, idex_regWrite;
    logic [DATA_W-1:0] ex_opA, ex_opB;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;
    logic              stall_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic              m_valid, m_memRead, m_memWrite, m_regWrite, m_err;
    logic [4:0]        m_rs1, m_rs2, m_rd;
    logic [DATA_W-1:0] m_op1, m_op2;
    int                m_scnt, m_fcnt, m_run;

    idex_hazard_resp_v #(.DATA_W(DATA_W), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_regWrite(id_regWrite),
        .id_op1(id_op1), .id_op2(id_op2), .forwA(forwA), .forwB(forwB),
        .exmem_alu(exmem_alu), .memwb_wdata(memwb_wdata),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_valid(idex_valid),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_memRead(idex_memRead), .idex_memWrite(idex_memWrite), .idex_regWrite(idex_regWrite),
        .ex_opA(ex_opA), .ex_opB(ex_opB), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        {m_valid, m_memRead, m_memWrite, m_regWrite, m_err} = '0;
        {m_rs1, m_rs2, m_rd} = '0;
        m_op1 = '0; m_op2 = '0;
        m_scnt = 0; m_fcnt = 0; m_run = 0;
    endfunction

    function automatic void model_edge();
        if (stall || flush) begin
            {m_valid, m_memRead, m_memWrite, m_regWrite} = '0;
            {m_rs1, m_rs2, m_rd} = '0;
            m_op1 = '0; m_op2 = '0;
        end else begin
            m_valid = id_valid; m_memRead = id_memRead; m_memWrite = id_memWrite;
            m_regWrite = id_regWrite; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
            m_op1 = id_op1; m_op2 = id_op2;
        end
        if (flush) begin
            if (m_fcnt < CNT_TOP) m_fcnt++;
            m_run = 0;
        end else if (stall) begin
            if (m_scnt < CNT_TOP) m_scnt++;
            m_run++;
            if (m_run > MAX_STALL) m_err = 1'b1;
        end else begin
            m_run = 0;
        end
    endfunction

    function automatic logic [DATA_W-1:0] fwd(input logic [1:0] sel, input logic [DATA_W-1:0] own);
        if (sel == 2'd1) return exmem_alu;
        if (sel == 2'd2) return memwb_wdata;
        return own;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic rw,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_memRead = mr; id_memWrite = mw; id_regWrite = rw; id_op1 = a; id_op2 = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall = 0; flush = 0; forwA = 0; forwB = 0; exmem_alu = 0; memwb_wdata = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if ({idex_valid, idex_memRead, idex_memWrite, idex_regWrite} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {idex_valid, idex_memRead, idex_memWrite, idex_regWrite});
        end
        n_checks++;
        if ({idex_rs1, idex_rs2, idex_rd} !== 15'd0) begin
            n_fail++; $display("FAIL reset_idx: got %h want 0", {idex_rs1, idex_rs2, idex_rd});
        end
        n_checks++;
        if ({stall_cnt, flush_cnt, stall_err} !== '0) begin
            n_fail++; $display("FAIL reset_stats: stall_cnt=%0d flush_cnt=%0d err=%b want 0", stall_cnt, flush_cnt, stall_err);
        end
        n_checks++;
        if ({pc_en, ifid_en} !== 2'b11) begin
            n_fail++; $display("FAIL reset_en: got %b want 11", {pc_en, ifid_en});
        end
        n_checks++;
        if ({ex_opA, ex_opB} !== '0) begin
            n_fail++; $display("FAIL reset_ops: got %h %h want 0", ex_opA, ex_opB);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 5'd2, 5'd0, 5'd5, 1, 0, 1, 32'h100, 32'h0);   // lw x5
        step();
        set_id(1, 5'd5, 5'd1, 5'd6, 0, 0, 1, 32'h7, 32'h3);     // add x6,x5,x1
        stall = 1;
        #1;
        n_checks++;
        if ({pc_en, ifid_en} !== 2'b00) begin
            n_fail++; $display("FAIL lu_freeze: got %b want 00", {pc_en, ifid_en});
        end
        step();
        stall = 0;
        n_checks++;
        if ({idex_valid, idex_regWrite, idex_rd} !== 7'd0) begin
            n_fail++; $display("FAIL lu_bubble: valid=%b rw=%b rd=%0d want 0/0/0", idex_valid, idex_regWrite, idex_rd);
        end
        #1;
        n_checks++;
        if (pc_en !== 1'b1) begin
            n_fail++; $display("FAIL lu_release: pc_en=%b want 1", pc_en);
        end
        step();
        n_checks++;
        if ({idex_valid, idex_rs1, idex_rd, idex_regWrite} !== {1'b1, 5'd5, 5'd6, 1'b1}) begin
            n_fail++; $display("FAIL lu_add: valid=%b rs1=%0d rd=%0d rw=%b want 1/5/6/1", idex_valid, idex_rs1, idex_rd, idex_regWrite);
        end
        n_checks++;
        if (stall_cnt !== 4'd1) begin
            n_fail++; $display("FAIL lu_cnt: stall_cnt=%0d want 1", stall_cnt);
        end
    endtask

    task automatic test_forwarding();
        logic [DATA_W-1:0] want_a [4];
        logic [DATA_W-1:0] want_b [4];
        want_a[0] = 32'h11; want_a[1] = 32'hAA; want_a[2] = 32'hBB; want_a[3] = 32'h11;
        want_b[0] = 32'h22; want_b[1] = 32'hAA; want_b[2] = 32'hBB; want_b[3] = 32'h22;
        do_reset();
        set_id(1, 1, 2, 3, 0, 0, 1, 32'h11, 32'h22);
        exmem_alu = 32'hAA; memwb_wdata = 32'hBB;
        step();
        for (int s = 0; s < 4; s++) begin
            forwA = s[1:0]; forwB = 2'(3 - s);
            #1;
            n_checks++;
            if (ex_opA !== want_a[s]) begin
                n_fail++; $display("FAIL fwdA sel=%0d: got %h want %h", s, ex_opA, want_a[s]);
            end
            n_checks++;
            if (ex_opB !== want_b[3 - s]) begin
                n_fail++; $display("FAIL fwdB sel=%0d: got %h want %h", 3 - s, ex_opB, want_b[3 - s]);
            end
        end
        forwA = 0; forwB = 0;
    endtask

    task automatic test_stall_flush();
        do_reset();
        set_id(1, 4, 4, 4, 1, 1, 1, 32'h5, 32'h6);
        step();
        stall = 1; flush = 1;
        #1;
        n_checks++;
        if (pc_en !== 1'b1) begin
            n_fail++; $display("FAIL sf_pc_en: got %b want 1", pc_en);
        end
        step();
        flush = 0;
        n_checks++;
        if ({idex_valid, idex_memRead, idex_memWrite, idex_regWrite} !== 4'b0) begin
            n_fail++; $display("FAIL sf_bubble: got %b want 0000", {idex_valid, idex_memRead, idex_memWrite, idex_regWrite});
        end
        n_checks++;
        if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin
            n_fail++; $display("FAIL sf_cnt: flush=%0d stall=%0d want 1/0", flush_cnt, stall_cnt);
        end
        // Three plain stalls after the combined cycle must not trip the watchdog if FSM stayed in RUN.
        repeat (3) step();
        stall = 0;
        n_checks++;
        if (stall_err !== 1'b0) begin
            n_fail++; $display("FAIL sf_fsm: stall_err=%b want 0", stall_err);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        stall = 1;
        repeat (3) step();
        n_checks++;
        if (stall_err !== 1'b0) begin
            n_fail++; $display("FAIL wd_early: stall_err=%b want 0 after 3 stalls", stall_err);
        end
        step();
        stall = 0;
        n_checks++;
        if (stall_err !== 1'b1) begin
            n_fail++; $display("FAIL wd_set: stall_err=%b want 1 after 4 stalls", stall_err);
        end
        repeat (3) step();
        n_checks++;
        if (stall_err !== 1'b1) begin
            n_fail++; $display("FAIL wd_sticky: stall_err=%b want 1", stall_err);
        end
        rst_n = 0;
        #1;
        n_checks++;
        if (stall_err !== 1'b0) begin
            n_fail++; $display("FAIL wd_clear: stall_err=%b want 0", stall_err);
        end
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            stall = 1; step();
            stall = 0; step();
        end
        n_checks++;
        if (stall_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_stall: stall_cnt=%0d want 15", stall_cnt);
        end
        flush = 1;
        repeat (18) step();
        flush = 0;
        n_checks++;
        if (flush_cnt !== 4'd15) begin
            n_fail++; $display("FAIL sat_flush: flush_cnt=%0d want 15", flush_cnt);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(1, 7, 8, 9, 0, 0, 1, 32'h1234, 32'h5678);
        step();
        stall = 1;
        repeat (2) step();
        rst_n = 0;
        #2;
        model_reset();
        n_checks++;
        if ({idex_valid, idex_rd, stall_cnt, flush_cnt, stall_err, ex_opA} !== '0) begin
            n_fail++; $display("FAIL mid_reset: valid=%b rd=%0d scnt=%0d fcnt=%0d err=%b opA=%h want all 0",
                               idex_valid, idex_rd, stall_cnt, flush_cnt, stall_err, ex_opA);
        end
        stall = 0;
        #1;
        rst_n = 1;
        set_id(1, 10, 11, 12, 0, 0, 1, 32'hCAFE, 32'hF00D);
        step();
        n_checks++;
        if ({idex_valid, idex_rd, ex_opA} !== {1'b1, 5'd12, 32'hCAFE}) begin
            n_fail++; $display("FAIL mid_reload: valid=%b rd=%0d opA=%h want 1/12/cafe", idex_valid, idex_rd, ex_opA);
        end
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] ea, eb;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            if (c >= 200 && c < 260) stall = 1;
            flush = ($urandom_range(0, 7) == 0);
            set_id($urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom);
            forwA = 2'($urandom); forwB = 2'($urandom);
            exmem_alu = $urandom; memwb_wdata = $urandom;
            #1;
            ea = fwd(forwA, m_op1);
            eb = fwd(forwB, m_op2);
            n_checks++;
            if ({pc_en, ifid_en, ex_opA, ex_opB} !== {{2{~(stall & ~flush)}}, ea, eb}) begin
                n_fail++; $display("FAIL rnd_comb c=%0d: en=%b%b opA=%h opB=%h want en=%b opA=%h opB=%h",
                                   c, pc_en, ifid_en, ex_opA, ex_opB, ~(stall & ~flush), ea, eb);
            end
            step();
            n_checks++;
            if ({idex_valid, idex_rs1, idex_rs2, idex_rd, idex_memRead, idex_memWrite, idex_regWrite,
                 stall_cnt, flush_cnt, stall_err} !==
                {m_valid, m_rs1, m_rs2, m_rd, m_memRead, m_memWrite, m_regWrite,
                 CNT_W'(m_scnt), CNT_W'(m_fcnt), m_err}) begin
                n_fail++; $display("FAIL rnd_reg c=%0d: v=%b rs=%0d/%0d rd=%0d c=%b%b%b sc=%0d fc=%0d err=%b want v=%b rs=%0d/%0d rd=%0d c=%b%b%b sc=%0d fc=%0d err=%b",
                                   c, idex_valid, idex_rs1, idex_rs2, idex_rd, idex_memRead, idex_memWrite, idex_regWrite,
                                   stall_cnt, flush_cnt, stall_err, m_valid, m_rs1, m_rs2, m_rd,
                                   m_memRead, m_memWrite, m_regWrite, m_scnt, m_fcnt, m_err);
            end
        end
        stall = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_stall_flush();
        test_watchdog();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
